// File: rtl/seq_mult_shift_add.sv
// Multi-cycle shift-and-add multiplier, one partial product per clock.
// Signed mode multiplies magnitudes and negates the final sum when the signs differ.
module seq_mult_shift_add #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_signed,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] mag_a_reg, mag_b_reg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             neg_reg;
  logic [PW-1:0]    acc_reg, acc_next;
  logic [PW-1:0]    product_reg;
  logic [CW-1:0]    step_reg;
  logic             last_step;
  logic             accept;
  logic [PW-1:0]    shifted [WIDTH];

  // Pre-shifted copies of the multiplicand, one per step position.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
      assign shifted[gi] = {{WIDTH{1'b0}}, mag_a_reg} << gi;
    end
  endgenerate

  // -(-2^(W-1)) wraps to 2^(W-1), which is the correct unsigned magnitude.
  assign a_mag = (in_signed && a[WIDTH-1]) ? -a : a;
  assign b_mag = (in_signed && b[WIDTH-1]) ? -b : b;

  assign last_step = (step_reg == CW'(WIDTH - 1));
  assign acc_next  = acc_reg + (mag_b_reg[step_reg] ? shifted[step_reg] : '0);
  assign product   = product_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept     = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        busy = 1'b1;
        if (last_step) state_next = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mag_a_reg   <= '0;
      mag_b_reg   <= '0;
      neg_reg     <= 1'b0;
      acc_reg     <= '0;
      step_reg    <= '0;
      product_reg <= '0;
    end else if (accept) begin
      mag_a_reg <= a_mag;
      mag_b_reg <= b_mag;
      neg_reg   <= in_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
      acc_reg   <= '0;
      step_reg  <= '0;
    end else if (state_reg == BUSY) begin
      acc_reg <= acc_next;
      if (last_step) begin
        product_reg <= neg_reg ? -acc_next : acc_next;
      end else begin
        step_reg <= step_reg + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_seq_mult_shift_add.sv
// Scoreboard bench for seq_mult_shift_add: driver pushes model results, monitor pops on output handshakes.
module tb_seq_mult_shift_add;
  localparam int W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, in_valid, in_ready, in_signed, out_valid, out_ready, busy;
  logic [W-1:0]   a, b;
  logic [2*W-1:0] product;

  logic           in_valid8, in_ready8, in_signed8, out_valid8, out_ready8, busy8;
  logic [7:0]     a8, b8;
  logic [15:0]    product8;

  seq_mult_shift_add #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_signed(in_signed),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .product(product), .busy(busy)
  );

  seq_mult_shift_add #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .in_signed(in_signed8),
    .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8), .product(product8), .busy(busy8)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int txn = 0;
  logic [2*W-1:0] exp_q[$];
  int lat_q[$];
  bit rand_ready = 1'b0;
  bit ready_fixed = 1'b1;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_fixed;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  // Reference: interpret operands as integers and multiply, keep the low 2W bits.
  function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    int ix, iy;
    ix = int'(x);
    iy = int'(y);
    if (s && x[W-1]) ix -= (1 << W);
    if (s && y[W-1]) iy -= (1 << W);
    return (2*W)'(ix * iy);
  endfunction

  // Monitor: protocol checks every cycle, scoreboard compare on each output handshake.
  logic           prev_hold = 1'b0;
  logic           prev_valid = 1'b0;
  logic [2*W-1:0] prev_product = '0;
  always @(negedge clk) begin
    if (rst) begin
      prev_hold  = 1'b0;
      prev_valid = 1'b0;
    end else begin
      check("busy_vs_in_ready", busy, !in_ready);
      if (out_valid) check("in_ready_in_done", in_ready, 0);
      if (prev_hold) begin
        check("hold_out_valid", out_valid, 1);
        check("hold_product", product, prev_product);
      end
      if (out_valid && !prev_valid) begin
        if (lat_q.size() == 0) check("unexpected_out_valid", 1, 0);
        else check("latency", cyc - lat_q.pop_front(), W);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", product, 0 - 1);
        end else begin
          logic [2*W-1:0] e;
          e = exp_q.pop_front();
          txn++;
          $display("txn %0d product=%h expected=%h", txn, product, e);
          check("product", product, e);
        end
      end
      prev_hold    = out_valid && !out_ready;
      prev_product = product;
      prev_valid   = out_valid;
    end
  end

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic os, output int acc_cyc);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 0, 1);
      acc_cyc = -1;
      return;
    end
    in_valid  = 1'b1;
    a         = oa;
    b         = ob;
    in_signed = os;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    exp_q.push_back(model(oa, ob, os));
    lat_q.push_back(cyc);
    acc_cyc = cyc;
    a         = W'($urandom);
    b         = W'($urandom);
    in_signed = 1'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int t0, t1, t, n;
    logic [W-1:0] ra, rb;
    rst = 1'b1; in_valid = 1'b0; in_signed = 1'b0; a = '0; b = '0; out_ready = 1'b1;
    in_valid8 = 1'b0; in_signed8 = 1'b0; a8 = '0; b8 = '0; out_ready8 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_product", product, 0);
    rst = 1'b0;
    @(negedge clk);

    do_op(4'd14, 4'd13, 1'b0, t0);
    do_op(4'd14, 4'd15, 1'b0, t1);
    check("accept_spacing", t1 - t0, W + 2);
    do_op(4'b1110, 4'b0011, 1'b1, t);
    do_op(4'b1000, 4'b1000, 1'b1, t);
    do_op(4'b1000, 4'b1000, 1'b0, t);
    do_op(4'd0, 4'd9, 1'b1, t);
    wait_idle();

    // Backpressure: output held while in_valid is pulsed.
    ready_fixed = 1'b0;
    @(negedge clk);
    do_op(4'b1011, 4'd7, 1'b1, t);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("bp_out_valid", out_valid, 1);
    repeat (5) begin
      in_valid = 1'($urandom);
      a = W'($urandom);
      b = W'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    ready_fixed = 1'b1;
    wait_idle();

    // Reset during step 2 aborts the operation.
    do_op(4'd9, 4'd11, 1'b0, t);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    lat_q.delete();
    @(negedge clk);
    check("abort_out_valid", out_valid, 0);
    check("abort_product", product, 0);
    check("abort_in_ready", in_ready, 1);
    rst = 1'b0;
    repeat (W + 2) begin
      @(negedge clk);
      check("no_stale_output", out_valid, 0);
    end
    do_op(4'd12, 4'd5, 1'b0, t);
    wait_idle();

    // Randomized traffic with random output backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 120; i++) begin
      ra = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_op(ra, rb, 1'($urandom), t);
    end
    wait_idle();
    rand_ready = 1'b0;

    // WIDTH=8 instance: full-scale unsigned operands.
    check("w8_in_ready", in_ready8, 1);
    a8 = 8'hFF; b8 = 8'hFF; in_signed8 = 1'b0; in_valid8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid8 = 1'b0;
    in_signed8 = 1'b1;
    n = 0;
    while (!out_valid8 && n < 30) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    check("w8_latency", n, 8);
    check("w8_product", product8, 16'hFE01);
    check("w8_busy", busy8, 1);
    @(negedge clk);
    check("w8_back_idle", in_ready8, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
